// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: Bee-Scape obstacle field sequencer.
// Spawns, scrolls, retires and scores N_OBS obstacle slots once per video frame.
module obstacle_scheduler #(
  parameter int unsigned N_OBS        = 3,
  parameter int unsigned SPAWN_X      = 640,
  parameter int unsigned SPAWN_PERIOD = 90,
  parameter int unsigned Y_MIN        = 100,
  parameter int unsigned Y_RESET      = 242,
  parameter int unsigned PLAYER_X     = 120
) (
  input  logic                 frame_clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 collide,
  input  logic [2:0]           speed,
  output logic [10*N_OBS-1:0]  ObsX,
  output logic [10*N_OBS-1:0]  ObsY,
  output logic [N_OBS-1:0]     ObsActive,
  output logic [9:0]           score,
  output logic                 pass_pulse,
  output logic                 running,
  output logic                 halted
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  localparam int unsigned CNT_W = $clog2(SPAWN_PERIOD);
  localparam int unsigned PC_W  = $clog2(N_OBS + 1);
  localparam logic [9:0]       SPAWN_X_C  = 10'(SPAWN_X);
  localparam logic [9:0]       Y_MIN_C    = 10'(Y_MIN);
  localparam logic [9:0]       Y_RESET_C  = 10'(Y_RESET);
  localparam logic [9:0]       PLAYER_X_C = 10'(PLAYER_X);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SPAWN_PERIOD - 1);

  state_t                  state_q, state_d;
  logic [N_OBS-1:0][9:0]   x_q, x_d, y_q, y_d;
  logic [N_OBS-1:0]        act_q, act_d;
  logic [9:0]              score_q, score_d;
  logic                    pulse_q, pulse_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic                    running_q, halted_q;

  logic [9:0]              spd10;
  logic [9:0]              nx;
  logic [PC_W-1:0]         pass_cnt;
  logic                    found;
  logic [11:0]             score_sum;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    act_d     = act_q;
    score_d   = score_q;
    pulse_d   = 1'b0;
    cnt_d     = cnt_q;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    spd10     = {7'b0, speed};
    nx        = '0;
    pass_cnt  = '0;
    found     = 1'b0;
    score_sum = '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          score_d = '0;
        end
      end
      S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          score_d = '0;
          x_d     = {N_OBS{SPAWN_X_C}};
          y_d     = {N_OBS{Y_RESET_C}};
          act_d   = '0;
        end
      end
      S_RUN: begin
        if (collide) begin
          state_d = S_HALT;
        end else begin
          for (int unsigned i = 0; i < N_OBS; i++) begin
            if (act_q[i]) begin
              if (x_q[i] < spd10) begin
                act_d[i] = 1'b0;
                x_d[i]   = SPAWN_X_C;
                y_d[i]   = Y_RESET_C;
              end else begin
                nx     = x_q[i] - spd10;
                x_d[i] = nx;
                if (x_q[i] >= PLAYER_X_C && nx < PLAYER_X_C)
                  pass_cnt = pass_cnt + PC_W'(1);
              end
            end
          end
          // Free means inactive before this frame; a slot retiring now waits a frame.
          if (cnt_q == CNT_LAST) begin
            for (int unsigned i = 0; i < N_OBS; i++) begin
              if (!act_q[i] && !found) begin
                found    = 1'b1;
                act_d[i] = 1'b1;
                x_d[i]   = SPAWN_X_C;
                y_d[i]   = Y_MIN_C + {3'b0, lfsr_q[6:0]};
              end
            end
            if (found) cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          score_sum = 12'(score_q) + 12'(pass_cnt);
          score_d   = (score_sum > 12'd1023) ? '1 : score_sum[9:0];
          pulse_d   = (pass_cnt != '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      x_q       <= {N_OBS{SPAWN_X_C}};
      y_q       <= {N_OBS{Y_RESET_C}};
      act_q     <= '0;
      score_q   <= '0;
      pulse_q   <= 1'b0;
      cnt_q     <= '0;
      lfsr_q    <= 8'hA5;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      act_q     <= act_d;
      score_q   <= score_d;
      pulse_q   <= pulse_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      running_q <= (state_d == S_RUN);
      halted_q  <= (state_d == S_HALT);
    end
  end

  assign ObsX       = x_q;
  assign ObsY       = y_q;
  assign ObsActive  = act_q;
  assign score      = score_q;
  assign pass_pulse = pulse_q;
  assign running    = running_q;
  assign halted     = halted_q;

endmodule
